sdram_req_bridge: RTL and testbench
===================================

# sdram_req_bridge

Multi-channel bridge from strobe-style CPU/peripheral RAM accesses (cs/oe/we levels plus address) to the toggle-handshake port of the shared `sdram` controller. Each channel gets edge and address-change detection, a one-deep pending slot, byte-lane generation and a per-channel read-data latch. Channels are arbitrated round-robin onto one SDRAM port, with an ack timeout. This block replaces the ad-hoc request logic in the core top level and generalises it to N requesters (CPU, disk DMA, tape loader) with configurable widths and an excluded (ROM/IO) address region.

## Interface
- CHANNELS, 2 — number of requester channels (1..4)
- AW, 16 — byte address width
- DW, 8 — channel data width; SDRAM port data is 2*DW
- EXCL_MASK, 16'hC000 — address bits compared for the excluded region (0 disables)
- EXCL_MATCH, 16'hC000 — excluded when (ad & EXCL_MASK) == EXCL_MATCH
- TIMEOUT, 255 — WAIT cycles before abort (≥4)

- clk_i  in  1  SDRAM-domain clock (clk_72); all channel inputs are synchronous to it
- res_n_i  in  1  asynchronous active-low reset
- ch_cs  in  CHANNELS  per-channel chip select
- ch_oe  in  CHANNELS  per-channel read enable
- ch_we  in  CHANNELS  per-channel write enable
- ch_ad  in  CHANNELS*AW  per-channel byte address; channel i at [i*AW +: AW]
- ch_d  in  CHANNELS*DW  per-channel write data
- ch_q  out  CHANNELS*DW  per-channel read data
- ch_busy  out  CHANNELS  channel has a pending or in-flight access
- ch_ovr  out  CHANNELS  sticky: pending access overwritten before issue
- tmo_err  out  1  sticky: ack timeout occurred
- port_req  out  1  request toggle
- port_ack  in  1  ack toggle; equals port_req when done
- port_a  out  AW  byte address of the access
- port_ds  out  2  byte strobes: write 2'b01 (a[0]=0) / 2'b10 (a[0]=1); read 2'b11
- port_we  out  1  write access
- port_d  out  2*DW  {d,d}
- port_q  in  2*DW  read data

## Operation
- Per channel i, registered history: cs&we, cs&oe, address (reset 0).
- Event when NOT excluded(ad) AND any of: cs&oe rising; cs&we rising; cs&oe held with ad ≠ previous ad. Write takes precedence: event is a write if we=1.
- Event loads pending slot {ad, we, d}; sets pend[i]. If pend[i] already set, slot overwritten (newest wins), ch_ovr[i] set.
- FSM IDLE/ISSUE/WAIT, reset IDLE. Arbiter pointer rr, reset 0.
- IDLE: if any pend, grant first set pend at or after rr (cyclic); → ISSUE.
- ISSUE: copy granted slot into in-flight regs driving port_a/ds/we/d; clear pend[g] (unless an event for g arrives this same cycle, which re-sets it with new contents, no ovr); toggle port_req; rr ← g+1 mod CHANNELS; → WAIT.
- WAIT: when port_ack == port_req: if read, ch_q[g] ← port_q[15:8] when a[0]=1 else port_q[7:0] (DW slices); → IDLE. Writes leave ch_q unchanged.
- Timeout: counter cleared in ISSUE, increments in WAIT; reaching TIMEOUT sets tmo_err, forces port_req ← port_ack (resync), → IDLE, access dropped, ch_q unchanged.
- ch_busy[i] = pend[i] | (state≠IDLE & g==i).
- ch_q[i] reads 0 while ch_cs[i]=0 or ch_ad[i] excluded; else latched value.

## Timing
- Reset (async assert, sync release): port_req 0, port_a/ds/we/d 0, ch_q latches 0, ch_busy 0, ch_ovr 0, tmo_err 0, pend 0, state IDLE.
- Event in cycle k → pend set at end of k → IDLE grant end of k+1 → port_req toggles end of k+2.
- Read data visible on ch_q the cycle after ack match is sampled; minimum request-to-data = ack latency + 3 cycles.
- Back-to-back grants: at most one access per 3 cycles plus ack latency.
- port_a/ds/we/d stable from toggle until return to IDLE.
- Reset mid-WAIT: transaction abandoned; port_req returns to 0 (controller assumed reset together).

## Test plan
- Single read ch0 ad=16'h1235, port_q=16'hA55A, ack 4 cycles after toggle -> port_ds=2'b11, port_a=16'h1235, ch_q[0]=8'hA5, busy drops.
- Write ch1 ad=16'h0400 d=8'h3C -> port_we=1, port_ds=2'b01, port_d=16'h3C3C; ch_q[1] unchanged.
- ch0 and ch1 events same cycle, repeated -> grants alternate 0,1,0,1; no ovr.
- ch0 oe held, ad steps 0010→0011 before issue -> single issue at 0011, ch_ovr[0]=1.
- Access ad=16'hC000 -> no port_req toggle, ch_q=0; ack never returned -> tmo_err=1 after TIMEOUT, next access completes normally.

Source files
------------

// File: rtl/sdram_req_bridge_if.sv
// Toggle-handshake request port between the request bridge (master) and the
// shared SDRAM controller (slave).
interface sdram_req_bridge_if #(
   parameter int AW = 16,
   parameter int DW = 8
) ();
   logic              port_req;
   logic              port_ack;
   logic [AW-1:0]     port_a;
   logic [1:0]        port_ds;
   logic              port_we;
   logic [2*DW-1:0]   port_d;
   logic [2*DW-1:0]   port_q;

   modport master (
      output port_req, port_a, port_ds, port_we, port_d,
      input  port_ack, port_q
   );

   modport slave (
      input  port_req, port_a, port_ds, port_we, port_d,
      output port_ack, port_q
   );
endinterface

// File: rtl/sdram_req_bridge.sv
// Multi-channel bridge from strobe-style RAM accesses to the SDRAM toggle
// handshake: per-channel event detect and pending slot, round-robin arbiter.
module sdram_req_bridge #(
   parameter int              CHANNELS   = 2,
   parameter int              AW         = 16,
   parameter int              DW         = 8,
   parameter logic [AW-1:0]   EXCL_MASK  = 16'hC000,
   parameter logic [AW-1:0]   EXCL_MATCH = 16'hC000,
   parameter int              TIMEOUT    = 255
) (
   input  logic                   clk_i,
   input  logic                   res_n_i,
   input  logic [CHANNELS-1:0]    ch_cs,
   input  logic [CHANNELS-1:0]    ch_oe,
   input  logic [CHANNELS-1:0]    ch_we,
   input  logic [CHANNELS*AW-1:0] ch_ad,
   input  logic [CHANNELS*DW-1:0] ch_d,
   output logic [CHANNELS*DW-1:0] ch_q,
   output logic [CHANNELS-1:0]    ch_busy,
   output logic [CHANNELS-1:0]    ch_ovr,
   output logic                   tmo_err,
   sdram_req_bridge_if.master     port
);

   localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   logic [CHANNELS-1:0] csWeNow, csOeNow;
   logic [CHANNELS-1:0] csWe_q, csOe_q;
   logic [AW-1:0]       adPrev_q [CHANNELS];
   logic [AW-1:0]       chAd     [CHANNELS];
   logic [CHANNELS-1:0] excl, ev, issueClr;

   logic [CHANNELS-1:0] pend_q, ovr_q, pendWe_q;
   logic [AW-1:0]       pendAd_q [CHANNELS];
   logic [DW-1:0]       pendD_q  [CHANNELS];
   logic [DW-1:0]       latQ_q   [CHANNELS];

   state_t              state_q;
   logic [GW-1:0]       g_q, rr_q, grant_d, nextRr_d;
   logic                grantFound;
   logic                req_q, we_q, tmoErr_q;
   logic [AW-1:0]       a_q;
   logic [1:0]          ds_q;
   logic [2*DW-1:0]     d_q;
   logic [TW-1:0]       tmo_q;

   assign csWeNow = ch_cs & ch_we;
   assign csOeNow = ch_cs & ch_oe;

   // An access starts on a read/write strobe rising, or when a held read moves to a new address.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         chAd[i]     = ch_ad[i*AW +: AW];
         excl[i]     = (EXCL_MASK != '0) && ((chAd[i] & EXCL_MASK) == EXCL_MATCH);
         ev[i]       = !excl[i] &&
                       ((csOeNow[i] && !csOe_q[i]) ||
                        (csWeNow[i] && !csWe_q[i]) ||
                        (csOeNow[i] && csOe_q[i] && (chAd[i] != adPrev_q[i])));
         issueClr[i] = (state_q == S_ISSUE) && (g_q == GW'(i));
      end
   end

   always_comb begin
      grant_d    = rr_q;
      grantFound = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!grantFound && pend_q[i] && (((int'(rr_q) + k) % CHANNELS) == i)) begin
               grant_d    = GW'(i);
               grantFound = 1'b1;
            end
         end
      end
      nextRr_d = (int'(g_q) == CHANNELS - 1) ? '0 : g_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         csWe_q   <= '0;
         csOe_q   <= '0;
         pend_q   <= '0;
         ovr_q    <= '0;
         pendWe_q <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            adPrev_q[i] <= '0;
            pendAd_q[i] <= '0;
            pendD_q[i]  <= '0;
         end
      end else begin
         csWe_q <= csWeNow;
         csOe_q <= csOeNow;
         for (int i = 0; i < CHANNELS; i++) begin
            adPrev_q[i] <= chAd[i];
            // A fresh event during the issue cycle refills the slot without counting as an overrun.
            if (ev[i]) begin
               pendAd_q[i] <= chAd[i];
               pendWe_q[i] <= ch_we[i];
               pendD_q[i]  <= ch_d[i*DW +: DW];
               pend_q[i]   <= 1'b1;
               if (pend_q[i] && !issueClr[i])
                  ovr_q[i] <= 1'b1;
            end else if (issueClr[i]) begin
               pend_q[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         state_q  <= S_IDLE;
         g_q      <= '0;
         rr_q     <= '0;
         req_q    <= 1'b0;
         a_q      <= '0;
         ds_q     <= '0;
         we_q     <= 1'b0;
         d_q      <= '0;
         tmo_q    <= '0;
         tmoErr_q <= 1'b0;
         for (int i = 0; i < CHANNELS; i++)
            latQ_q[i] <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (|pend_q) begin
                  g_q     <= grant_d;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               a_q     <= pendAd_q[g_q];
               we_q    <= pendWe_q[g_q];
               ds_q    <= pendWe_q[g_q] ? (pendAd_q[g_q][0] ? 2'b10 : 2'b01) : 2'b11;
               d_q     <= {2{pendD_q[g_q]}};
               req_q   <= ~req_q;
               rr_q    <= nextRr_d;
               tmo_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (port.port_ack == req_q) begin
                  if (!we_q)
                     latQ_q[g_q] <= a_q[0] ? port.port_q[2*DW-1:DW] : port.port_q[DW-1:0];
                  state_q <= S_IDLE;
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  // Drop the access and realign the toggle pair so the next request starts clean.
                  tmoErr_q <= 1'b1;
                  req_q    <= port.port_ack;
                  state_q  <= S_IDLE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign port.port_req = req_q;
   assign port.port_a   = a_q;
   assign port.port_ds  = ds_q;
   assign port.port_we  = we_q;
   assign port.port_d   = d_q;
   assign ch_ovr        = ovr_q;
   assign tmo_err       = tmoErr_q;

   always_comb begin
      ch_busy = '0;
      ch_q    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         ch_busy[i]        = pend_q[i] | ((state_q != S_IDLE) && (g_q == GW'(i)));
         ch_q[i*DW +: DW]  = (ch_cs[i] && !excl[i]) ? latQ_q[i] : '0;
      end
   end

endmodule

// File: tb/tb_sdram_req_bridge.sv
// Randomized bench for sdram_req_bridge: a behavioural SDRAM controller answers
// the toggle port while a per-channel model predicts requests and read data.
module tb_sdram_req_bridge;

   localparam int CH  = 2;
   localparam int AW  = 16;
   localparam int DW  = 8;
   localparam int TMO = 255;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [CH-1:0]     chCs, chOe, chWe;
   logic [CH*AW-1:0]  chAd;
   logic [CH*DW-1:0]  chD;
   logic [CH*DW-1:0]  chQ;
   logic [CH-1:0]     chBusy, chOvr;
   logic              tmoErr;

   sdram_req_bridge_if #(.AW(AW), .DW(DW)) ifc ();

   sdram_req_bridge #(
      .CHANNELS(CH), .AW(AW), .DW(DW),
      .EXCL_MASK(16'hC000), .EXCL_MATCH(16'hC000), .TIMEOUT(TMO)
   ) dut (
      .clk_i(clk), .res_n_i(rst_n),
      .ch_cs(chCs), .ch_oe(chOe), .ch_we(chWe), .ch_ad(chAd), .ch_d(chD),
      .ch_q(chQ), .ch_busy(chBusy), .ch_ovr(chOvr), .tmo_err(tmoErr),
      .port(ifc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0]   a;
      logic [1:0]      ds;
      logic            we;
      logic [2*DW-1:0] d;
      logic [2*DW-1:0] q;
   } req_t;

   req_t            reqQ[$];
   bit              ackEnable = 1'b1;
   int              ackLat    = 4;
   bit              useNextQ  = 1'b0;
   logic [2*DW-1:0] nextQ     = '0;
   int              checkCount = 0;
   int              passCount  = 0;
   logic [DW-1:0]   expQ [CH];
   int              modelRr = 0;

   // Controller model: logs every new request, answers after ackLat cycles unless disabled.
   initial begin
      logic prevReq;
      req_t r;
      ifc.port_ack = 1'b0;
      ifc.port_q   = '0;
      prevReq      = 1'b0;
      forever begin
         @(negedge clk);
         if (ifc.port_req !== prevReq && ifc.port_req !== ifc.port_ack) begin
            r.a  = ifc.port_a;
            r.ds = ifc.port_ds;
            r.we = ifc.port_we;
            r.d  = ifc.port_d;
            r.q  = useNextQ ? nextQ : 16'($urandom);
            useNextQ = 1'b0;
            reqQ.push_back(r);
            if (ackEnable) begin
               repeat (ackLat) @(negedge clk);
               ifc.port_q   = r.q;
               ifc.port_ack = ifc.port_req;
            end
         end
         prevReq = ifc.port_req;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic applyStimulus(input int ch, input logic cs, input logic oe, input logic we,
                                input logic [AW-1:0] ad, input logic [DW-1:0] d);
      chCs[ch]          = cs;
      chOe[ch]          = oe;
      chWe[ch]          = we;
      chAd[ch*AW +: AW] = ad;
      chD[ch*DW +: DW]  = d;
   endtask

   task automatic waitReq(output req_t r);
      int n = 0;
      while (reqQ.size() == 0 && n < 60) begin
         step(1);
         n++;
      end
      if (reqQ.size() == 0) begin
         checkOutput("req_seen", 32'd0, 32'd1);
         r = '0;
      end else begin
         r = reqQ.pop_front();
      end
   endtask

   task automatic waitIdle(input int limit);
      int n = 0;
      while (chBusy != '0 && n < limit) begin
         step(1);
         n++;
      end
      if (chBusy != '0)
         checkOutput("idle_wait", 32'(chBusy), 32'd0);
   endtask

   function automatic logic [AW-1:0] randAd();
      logic [AW-1:0] a = AW'($urandom);
      if ((a & 16'hC000) == 16'hC000)
         a[15] = 1'b0;
      return a;
   endfunction

   function automatic logic [DW-1:0] laneOf(input logic [2*DW-1:0] q, input logic odd);
      return odd ? q[2*DW-1:DW] : q[DW-1:0];
   endfunction

   task automatic readTxn(input int ch, input logic [AW-1:0] ad);
      req_t r;
      applyStimulus(ch, 1'b1, 1'b1, 1'b0, ad, '0);
      waitReq(r);
      checkOutput("rd_addr", 32'(r.a), 32'(ad));
      checkOutput("rd_ds", 32'(r.ds), 32'd3);
      checkOutput("rd_we", 32'(r.we), 32'd0);
      waitIdle(100);
      expQ[ch] = laneOf(r.q, ad[0]);
      checkOutput("rd_data", 32'(chQ[ch*DW +: DW]), 32'(expQ[ch]));
      modelRr = (ch + 1) % CH;
      applyStimulus(ch, 1'b0, 1'b0, 1'b0, ad, '0);
      step(1);
      checkOutput("rd_csoff_q", 32'(chQ[ch*DW +: DW]), 32'd0);
   endtask

   task automatic writeTxn(input int ch, input logic [AW-1:0] ad, input logic [DW-1:0] d);
      req_t r;
      applyStimulus(ch, 1'b1, 1'b0, 1'b1, ad, d);
      waitReq(r);
      checkOutput("wr_addr", 32'(r.a), 32'(ad));
      checkOutput("wr_we", 32'(r.we), 32'd1);
      checkOutput("wr_ds", 32'(r.ds), ad[0] ? 32'd2 : 32'd1);
      checkOutput("wr_data", 32'(r.d), 32'({d, d}));
      waitIdle(100);
      checkOutput("wr_q_keep", 32'(chQ[ch*DW +: DW]), 32'(expQ[ch]));
      modelRr = (ch + 1) % CH;
      applyStimulus(ch, 1'b0, 1'b0, 1'b0, ad, '0);
      step(1);
   endtask

   initial begin
      req_t            r, r2;
      logic [AW-1:0]   ad0, ad1;
      int              first, second;
      chCs = '0; chOe = '0; chWe = '0; chAd = '0; chD = '0;
      rst_n = 1'b1;
      for (int i = 0; i < CH; i++) expQ[i] = '0;
      #1 rst_n = 1'b0;
      step(3);
      checkOutput("rst_req", 32'(ifc.port_req), 32'd0);
      checkOutput("rst_a", 32'(ifc.port_a), 32'd0);
      checkOutput("rst_ds", 32'(ifc.port_ds), 32'd0);
      checkOutput("rst_we", 32'(ifc.port_we), 32'd0);
      checkOutput("rst_d", 32'(ifc.port_d), 32'd0);
      checkOutput("rst_busy", 32'(chBusy), 32'd0);
      checkOutput("rst_ovr", 32'(chOvr), 32'd0);
      checkOutput("rst_tmo", 32'(tmoErr), 32'd0);
      rst_n = 1'b1;
      step(2);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 16'h1235, '0);
      step(1);
      checkOutput("rst_q0", 32'(chQ[DW-1:0]), 32'd0);

      $display("[TB] directed read with event-to-toggle latency");
      ackLat   = 4;
      nextQ    = 16'hA55A;
      useNextQ = 1'b1;
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 16'h1235, '0);
      step(2);
      checkOutput("lat_before", 32'(ifc.port_req), 32'd0);
      step(1);
      checkOutput("lat_toggle", 32'(ifc.port_req), 32'd1);
      checkOutput("busy_inflight", 32'(chBusy[0]), 32'd1);
      waitReq(r);
      checkOutput("dir_addr", 32'(r.a), 32'h1235);
      checkOutput("dir_ds", 32'(r.ds), 32'd3);
      waitIdle(50);
      expQ[0] = 8'hA5;
      checkOutput("dir_q", 32'(chQ[DW-1:0]), 32'hA5);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h1235, '0);
      modelRr = 1;
      step(1);

      $display("[TB] directed write");
      writeTxn(1, 16'h0400, 8'h3C);

      $display("[TB] random reads and writes");
      for (int n = 0; n < 8; n++) begin
         ackLat = $urandom_range(1, 6);
         readTxn($urandom_range(0, CH - 1), randAd());
      end
      for (int n = 0; n < 6; n++) begin
         ackLat = $urandom_range(1, 6);
         writeTxn($urandom_range(0, CH - 1), randAd(), DW'($urandom));
      end

      $display("[TB] simultaneous events, round-robin order");
      for (int n = 0; n < 3; n++) begin
         ackLat = $urandom_range(1, 6);
         ad0    = randAd();
         ad1    = ad0 ^ 16'h0001;
         first  = modelRr;
         second = (first + 1) % CH;
         chCs = 2'b11; chOe = 2'b11; chWe = 2'b00;
         chAd = {ad1, ad0};
         waitReq(r);
         checkOutput("rr_first", 32'(r.a), first == 0 ? 32'(ad0) : 32'(ad1));
         waitReq(r2);
         checkOutput("rr_second", 32'(r2.a), second == 0 ? 32'(ad0) : 32'(ad1));
         waitIdle(100);
         expQ[first]  = laneOf(r.q, (first == 0) ? ad0[0] : ad1[0]);
         expQ[second] = laneOf(r2.q, (second == 0) ? ad0[0] : ad1[0]);
         checkOutput("rr_q0", 32'(chQ[DW-1:0]), 32'(expQ[0]));
         checkOutput("rr_q1", 32'(chQ[2*DW-1:DW]), 32'(expQ[1]));
         modelRr = (second + 1) % CH;
         chCs = '0; chOe = '0;
         step(1);
      end
      checkOutput("rr_no_ovr", 32'(chOvr), 32'd0);

      $display("[TB] address step before issue overwrites pending slot");
      ackLat = 3;
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 16'h0010, '0);
      step(1);
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 16'h0011, '0);
      waitReq(r);
      checkOutput("ovr_addr", 32'(r.a), 32'h0011);
      waitIdle(50);
      step(5);
      checkOutput("ovr_single", 32'(reqQ.size()), 32'd0);
      checkOutput("ovr_flag", 32'(chOvr), 32'd1);
      expQ[0] = laneOf(r.q, 1'b1);
      checkOutput("ovr_q", 32'(chQ[DW-1:0]), 32'(expQ[0]));
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0011, '0);
      modelRr = 1;
      step(1);

      $display("[TB] excluded region");
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 16'hC000, '0);
      step(10);
      checkOutput("excl_noreq", 32'(reqQ.size()), 32'd0);
      checkOutput("excl_q", 32'(chQ[DW-1:0]), 32'd0);
      checkOutput("excl_busy", 32'(chBusy), 32'd0);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0000, '0);
      step(1);

      $display("[TB] ack timeout");
      checkOutput("tmo_before", 32'(tmoErr), 32'd0);
      ackEnable = 1'b0;
      ad1 = randAd();
      applyStimulus(1, 1'b1, 1'b1, 1'b0, ad1, '0);
      waitReq(r);
      step(TMO - 20);
      checkOutput("tmo_early", 32'(tmoErr), 32'd0);
      waitIdle(100);
      checkOutput("tmo_set", 32'(tmoErr), 32'd1);
      checkOutput("tmo_resync", 32'(ifc.port_req), 32'(ifc.port_ack));
      checkOutput("tmo_q_keep", 32'(chQ[2*DW-1:DW]), 32'(expQ[1]));
      ackEnable = 1'b1;
      applyStimulus(1, 1'b0, 1'b0, 1'b0, ad1, '0);
      modelRr = 0;
      step(1);
      ackLat = 2;
      readTxn(1, randAd());

      $display("[TB] reset during wait");
      ackEnable = 1'b0;
      applyStimulus(0, 1'b1, 1'b1, 1'b0, randAd(), '0);
      waitReq(r);
      rst_n = 1'b0;
      ifc.port_ack = 1'b0;
      step(1);
      checkOutput("rstw_req", 32'(ifc.port_req), 32'd0);
      checkOutput("rstw_busy", 32'(chBusy), 32'd0);
      checkOutput("rstw_q", 32'(chQ[DW-1:0]), 32'd0);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < CH; i++) expQ[i] = '0;
      modelRr = 0;
      rst_n = 1'b1;
      ackEnable = 1'b1;
      step(2);
      readTxn(0, randAd());
      writeTxn(1, randAd(), DW'($urandom));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
